seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised Moore-style serial pattern detector with qualified input, selectable overlapping/non-overlapping matching and a saturating match counter. It extends the fixed single-pattern "0110" detector in the FSM library: pattern and length are parameters, input bits are qualified by a valid strobe, and matches are counted. It sits on a serial bit stream (one bit per accepted cycle) and feeds a registered one-cycle detect pulse and a match count to downstream control logic.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b0110: target sequence. The MSB is the first (oldest) bit received.
- CNT_W, 8: match counter width; legal range ≥1.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
- en  input  1  bit-valid; data_in is accepted only on edges where en=1.
- data_in  input  1  serial data bit.
- overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping; sampled on every accepted bit.
- clr  input  1  synchronous clear of history, fill, counter and data_out; priority over en.
- data_out  output  1  registered detect pulse.
- match_cnt  output  CNT_W  number of matches since reset/clr; saturating.
- cnt_sat  output  1  high while match_cnt is all-ones.

## Operation
- State:
  - hist[PAT_W-1:0]: shift register of accepted bits; new bit enters the LSB.
  - fill: counts 0..PAT_W and saturates at PAT_W.
  - match_cnt.
  - data_out register.
- Accepted bit (en=1, clr=0):
  - hist_next = {hist[PAT_W-2:0], data_in}.
  - fill_next = min(fill+1, PAT_W).
- Match condition on an accepted bit: fill_next == PAT_W and hist_next == PATTERN.
- On a match:
  - data_out←1.
  - match_cnt←match_cnt+1 unless already all-ones.
  - If overlap_en=0, fill←0, so the next match needs PAT_W fresh bits. hist is still loaded; fill gates validity.
  - If overlap_en=1, fill stays at PAT_W and the window keeps sliding.
- No match, or en=0: data_out←0. hist, fill and match_cnt hold when en=0.
- clr=1: hist←0, fill←0, match_cnt←0, data_out←0, regardless of en and data_in.
- Changing overlap_en mid-stream affects only matches on subsequent accepted bits; there is no retroactive effect.
- Counter arithmetic: unsigned CNT_W bits, no wrap. When match_cnt reaches 2^CNT_W−1 it holds there and cnt_sat=1. cnt_sat is combinational from match_cnt == all-ones.
- An all-zero PATTERN must not match before fill reaches PAT_W, i.e. never from reset contents alone.

## Timing
- Reset values (rst=0, asynchronous): data_out=0, match_cnt=0, cnt_sat=0, fill=0, hist=0. After rst deasserts, the first accepted edge can begin filling.
- Latency: data_out is high for exactly the one cycle after the edge that accepted the final pattern bit. It is a single-cycle pulse even if en drops.
- Back-to-back overlapping matches (e.g. PATTERN=11, stream 1,1,1) give data_out high on consecutive cycles.
- match_cnt updates on the same edge that sets data_out.
- Reset asserted mid-pattern discards the partial history. A pulse in flight is cleared asynchronously.
- Simultaneous clr and matching bit: clr wins; no pulse and no count.

## Test plan
- Reset: hold rst=0 with arbitrary en/data_in → data_out=0, match_cnt=0, cnt_sat=0. Assert rst low mid-pattern (after bits 0,1,1) then resume with bit 0 → no match.
- Overlap, PATTERN=0110, en=1 every cycle, overlap_en=1, stream 0,1,1,0,1,1,0,1,0,1,1,0 → pulses after bits 4, 7 and 12; match_cnt=3.
- Non-overlap, same stream, overlap_en=0 → pulses after bits 4 and 12 only; match_cnt=2.
- Gaps: stream 0,1,1,0 with en=0 for 3 cycles between each bit → exactly one pulse, one cycle after the edge accepting the final 0; match_cnt=1. Bits presented while en=0 are ignored.
- Saturation: CNT_W=2, overlap_en=1, PATTERN=11, stream of 6 ones → match_cnt sequence 1,2,3,3,3; cnt_sat=1 from the third match; data_out pulses on all five matches.
- clr priority: drive clr=1 on the edge accepting the final 0 of 0110 → no pulse, match_cnt=0, fill=0. The following 0,1,1,0 matches once.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector. Accepted bits shift into a history
// register; a fill counter gates validity so that reset contents never match.
// Matches raise a registered one-cycle pulse and bump a saturating counter.
module seq_detector_param #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             data_in,
  input  logic             overlap_en,
  input  logic             clr,
  output logic             data_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned      FillW    = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  logic [PAT_W-1:0] hist_shift;
  logic [FillW-1:0] fill_inc;
  logic             match;

  assign cnt_sat   = &cnt_q;
  assign match_cnt = cnt_q;
  assign data_out  = out_q;

  // Next-state: clr beats en; a match restarts fill only in non-overlapping mode.
  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], data_in};
    fill_inc   = (fill_q == FillFull) ? FillFull : fill_q + FillW'(1);
    match      = en && (fill_inc == FillFull) && (hist_shift == PATTERN);

    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    out_d  = 1'b0;

    if (clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      hist_d = hist_shift;
      fill_d = (match && !overlap_en) ? '0 : fill_inc;
      if (match) begin
        out_d = 1'b1;
        if (!cnt_sat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset drops any pulse in flight immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two instances (0110/8-bit counter and 11/2-bit
// counter) share one stimulus stream; a queue-based scoreboard checks both.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst, en, data_in, overlap_en, clr;
  logic       dout0, sat0, dout1, sat1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b0110), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .overlap_en(overlap_en),
    .clr(clr), .data_out(dout0), .match_cnt(cnt0), .cnt_sat(sat0)
  );

  seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .overlap_en(overlap_en),
    .clr(clr), .data_out(dout1), .match_cnt(cnt1), .cnt_sat(sat1)
  );

  typedef struct {
    logic       p0;
    logic [7:0] c0;
    logic       s0;
    logic       p1;
    logic [1:0] c1;
    logic       s1;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: bits accepted since the last restart, and a raw match count.
  bit w0[$];
  bit w1[$];
  int c0 = 0;
  int c1 = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // True when the window holds exactly pw bits equal to pat (oldest = MSB).
  function automatic bit tail_match(input bit w[$], input int pw, input logic [15:0] pat);
    if (w.size() != pw) return 1'b0;
    for (int i = 0; i < pw; i++) begin
      if (w[i] != pat[pw-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input logic r, input logic e, input logic d, input logic ov,
                      input logic c);
    exp_t x;
    bit   m0, m1;
    @(negedge clk);
    rst = r; en = e; data_in = d; overlap_en = ov; clr = c;
    m0 = 1'b0;
    m1 = 1'b0;
    if (!r || c) begin
      w0.delete(); w1.delete(); c0 = 0; c1 = 0;
    end else if (e) begin
      w0.push_back(d);
      if (w0.size() > 4) void'(w0.pop_front());
      m0 = tail_match(w0, 4, 16'h0006);
      if (m0) begin
        c0++;
        if (!ov) w0.delete();
      end
      w1.push_back(d);
      if (w1.size() > 2) void'(w1.pop_front());
      m1 = tail_match(w1, 2, 16'h0003);
      if (m1) begin
        c1++;
        if (!ov) w1.delete();
      end
    end
    x.p0 = m0;
    x.c0 = (c0 > 255) ? 8'hFF : 8'(c0);
    x.s0 = (c0 >= 255);
    x.p1 = m1;
    x.c1 = (c1 > 3) ? 2'd3 : 2'(c1);
    x.s1 = (c1 >= 3);
    exp_q.push_back(x);
  endtask

  task automatic bits(input logic [15:0] v, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, v[i], ov, 1'b0);
  endtask

  // Monitor: one expected record per clock edge, sampled just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("pulse0", int'(dout0), int'(x.p0));
        chk("cnt0", int'(cnt0), int'(x.c0));
        chk("sat0", int'(sat0), int'(x.s0));
        chk("pulse1", int'(dout1), int'(x.p1));
        chk("cnt1", int'(cnt1), int'(x.c1));
        chk("sat1", int'(sat1), int'(x.s1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; en = 1'b0; data_in = 1'b0; overlap_en = 1'b0; clr = 1'b0;
    // Held in reset with arbitrary inputs.
    repeat (4) step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    // Reset mid-pattern discards 0,1,1; a following 0 must not match.
    bits(16'b011, 3, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    bits(16'b0, 1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    // Overlapping then non-overlapping on the same stream.
    bits(16'b0110_1101_0110, 12, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bits(16'b0110_1101_0110, 12, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Gaps: bits presented while en=0 are ignored.
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, 1'b1, 1'(4'b0110 >> i), 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0);
    end
    // Saturation of the 2-bit counter on a run of ones.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    bits(16'b11_1111, 6, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // clr on the final matching bit wins, then a fresh match.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    bits(16'b011, 3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    bits(16'b0110, 4, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // A pulse in flight is cleared asynchronously by reset.
    bits(16'b0110, 4, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_pulse0", int'(dout0), 0);
    chk("async_cnt0", int'(cnt0), 0);
    chk("async_pulse1", int'(dout1), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Randomised traffic with occasional clr and reset.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 49) == 0));
    end
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
